// File: rtl/compuerta_pkg.sv
// Shared types and helpers for the parametrised parking-gate controller.
package compuerta_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ESPERA_PIN,
    ABIERTO,
    ALARMA,
    BLOQUEO
  } estado_t;

  // Open-timer width; clamped to 1 bit so T_ABIERTO=1 still yields a legal vector.
  function automatic int timer_w(input int t_abierto);
    return (t_abierto > 1) ? $clog2(t_abierto) : 1;
  endfunction

endpackage

// File: rtl/detector_intento.sv
// Keypad attempt detector: flags the idle-to-non-idle transition of the PIN.
module detector_intento
  import compuerta_pkg::*;
#(
  parameter int               PIN_W        = 8,
  parameter logic [PIN_W-1:0] PIN_ESPERA   = '0,
  parameter logic [PIN_W-1:0] PIN_CORRECTO = PIN_W'(8'b00001000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] pin,
  output logic             intento,
  output logic             pin_ok
);

  logic [PIN_W-1:0] pin_prev;
  logic             pin_en_reset;

  // A PIN already held during reset must not count as a fresh attempt on release,
  // while pin_prev itself still resets to the idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_prev     <= PIN_ESPERA;
      pin_en_reset <= (pin != PIN_ESPERA);
    end else begin
      pin_prev     <= pin;
      pin_en_reset <= 1'b0;
    end
  end

  assign intento = (pin != PIN_ESPERA) && (pin_prev == PIN_ESPERA) && !pin_en_reset;
  assign pin_ok  = (pin == PIN_CORRECTO);

endmodule

// File: rtl/controlador_compuerta_param.sv
// Parking-gate controller: PIN-gated barrier with attempt limit, open timeout and tailgating lockout.
module controlador_compuerta_param
  import compuerta_pkg::*;
#(
  parameter int               PIN_W        = 8,
  parameter logic [PIN_W-1:0] PIN_CORRECTO = PIN_W'(8'b00001000),
  parameter logic [PIN_W-1:0] PIN_ESPERA   = '0,
  parameter int               MAX_INTENTOS = 3,
  parameter int               T_ABIERTO    = 20,
  parameter int               CNT_W        = $clog2(MAX_INTENTOS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic [PIN_W-1:0] Pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [CNT_W-1:0] Intentos
);

  localparam int               TMR_W   = timer_w(T_ABIERTO);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INTENTOS);
  localparam logic [TMR_W-1:0] TMR_FIN = TMR_W'(T_ABIERTO - 1);

  estado_t          estado, estado_nxt;
  logic [CNT_W-1:0] intentos_nxt;
  logic [TMR_W-1:0] timer;
  logic             intento, pin_ok;

  detector_intento #(
    .PIN_W       (PIN_W),
    .PIN_ESPERA  (PIN_ESPERA),
    .PIN_CORRECTO(PIN_CORRECTO)
  ) u_detector (
    .clk    (Clk),
    .rst    (Reset),
    .pin    (Pin),
    .intento(intento),
    .pin_ok (pin_ok)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado   <= IDLE;
      Intentos <= '0;
      timer    <= '0;
    end else begin
      estado   <= estado_nxt;
      Intentos <= intentos_nxt;
      timer    <= (estado == ABIERTO && estado_nxt == ABIERTO) ? timer + TMR_W'(1) : '0;
    end
  end

  always_comb begin
    estado_nxt   = estado;
    intentos_nxt = Intentos;
    case (estado)
      IDLE: begin
        if (Vehiculo) estado_nxt = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        if (intento && pin_ok) begin
          estado_nxt   = ABIERTO;
          intentos_nxt = '0;
        end else if (intento) begin
          if (Intentos != CNT_MAX) intentos_nxt = Intentos + CNT_W'(1);
          if (intentos_nxt == CNT_MAX) estado_nxt = ALARMA;
        end else if (!Vehiculo) begin
          estado_nxt = IDLE;
        end
      end
      ABIERTO: begin
        // Termino is checked first so a simultaneous timeout cannot mask tailgating.
        if (Termino)               estado_nxt = Vehiculo ? BLOQUEO : IDLE;
        else if (timer == TMR_FIN) estado_nxt = IDLE;
      end
      ALARMA: begin
        if (intento && pin_ok) begin
          estado_nxt   = ABIERTO;
          intentos_nxt = '0;
        end
      end
      BLOQUEO: begin
        if (intento && pin_ok) begin
          estado_nxt   = IDLE;
          intentos_nxt = '0;
        end
      end
      default: estado_nxt = IDLE;
    endcase
  end

  always_comb begin
    Cerrado = (estado != ABIERTO);
    Abierto = (estado == ABIERTO);
    Alarma  = (estado == ALARMA) || (estado == BLOQUEO);
    Bloqueo = (estado == BLOQUEO);
  end

endmodule

// File: doc/controlador_compuerta_param.md
# controlador_compuerta_param

Parametrised parking-gate controller: a vehicle arrives, the driver enters a PIN, and the gate opens on a correct PIN and closes once the vehicle has passed. It supersedes the fixed 8-bit, fixed-policy controller driven by the existing `probador` bench. It adds configurable PIN width and values, a configurable wrong-attempt limit, an open-gate timeout, tailgating lockout and a visible attempt counter. It sits between the lane sensors/keypad and the barrier actuator and alarm.

## Interface
- `PIN_W`, 8, width of `Pin`.
- `PIN_CORRECTO`, 8'b00001000, the PIN that opens the gate.
- `PIN_ESPERA`, 8'b00000000, idle keypad value; means no entry.
- `MAX_INTENTOS`, 3, wrong attempts that raise `Alarma`; must be ≥1.
- `T_ABIERTO`, 20, cycles the gate stays open without `Termino` before auto-closing; must be ≥1.
- `CNT_W`, $clog2(MAX_INTENTOS+1), width of `Intentos`.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Vehiculo` in 1: a vehicle is present at the gate.
- `Termino` in 1: the vehicle has finished passing.
- `Pin` in `PIN_W`: keypad value; `PIN_ESPERA` when idle.
- `Cerrado` out 1: gate closed.
- `Abierto` out 1: gate open.
- `Alarma` out 1: too many wrong PINs, or tailgating.
- `Bloqueo` out 1: tailgating lockout.
- `Intentos` out `CNT_W`: wrong-attempt count, saturating at `MAX_INTENTOS`.

## Operation
- **Attempt definition.**
  - An attempt is registered in the cycle where `Pin != PIN_ESPERA` and the previous cycle's `Pin == PIN_ESPERA`.
  - Holding a non-idle value counts once only.
  - Changing directly from one non-idle value to another is not a new attempt.
- **States.**
  - **IDLE**: `Cerrado`=1. `Vehiculo`=1 → ESPERA_PIN.
  - **ESPERA_PIN**: `Cerrado`=1.
    - Correct attempt → ABIERTO and clear `Intentos`.
    - Wrong attempt → `Intentos`+1; if the new value equals `MAX_INTENTOS` → ALARMA.
    - `Vehiculo`=0 with no attempt → IDLE; `Intentos` is retained.
  - **ABIERTO**: `Abierto`=1, `Cerrado`=0. The open timer is loaded with 0 on entry.
    - `Termino`=1 and `Vehiculo`=0 → IDLE.
    - `Termino`=1 and `Vehiculo`=1 (a second vehicle is behind) → BLOQUEO.
    - Timer reaches `T_ABIERTO`-1 without `Termino` → IDLE.
  - **ALARMA**: `Alarma`=1, `Cerrado`=1.
    - Wrong attempts are ignored; `Intentos` stays saturated.
    - Correct attempt → ABIERTO and clear `Intentos`.
  - **BLOQUEO**: `Bloqueo`=1, `Alarma`=1, `Cerrado`=1.
    - Only a correct attempt exits; it goes to IDLE and clears `Intentos`.
    - `Vehiculo` and `Termino` are ignored.
- **Outputs.**
  - `Cerrado`, `Abierto`, `Alarma` and `Bloqueo` are pure Moore decodes of the state register.
  - `Intentos` is a register.
  - Exactly one of `Cerrado`/`Abierto` is high in every cycle.
- **Reset values.** State=IDLE, `Cerrado`=1, `Abierto`=0, `Alarma`=0, `Bloqueo`=0, `Intentos`=0, previous-`Pin` register=`PIN_ESPERA`, timer=0.
- **Priorities.**
  - `Reset` overrides everything.
  - In ESPERA_PIN, an attempt beats `Vehiculo` falling in the same cycle.
  - In ABIERTO, `Termino` beats the timeout in the same cycle.
  - Attempts in IDLE and ABIERTO are ignored and do not change `Intentos`. The previous-`Pin` register still updates.

## Timing
- **Sampling and update.** Inputs are sampled on the rising edge of `Clk`. State, `Intentos` and the outputs update on that same edge, so outputs are visible 1 cycle after the input condition is presented.
- **Correct-PIN latency.** A correct attempt sampled at edge N gives `Abierto`=1 after edge N.
- **Timeout.** With no `Termino`, the gate closes exactly `T_ABIERTO` cycles after entering ABIERTO.
- **Reset mid-operation.** Asserting `Reset` in any state forces the reset values at the next edge. A `Pin` that is non-idle while `Reset` is high does not count as an attempt in the first cycle after release.

## Structure
- **Package `compuerta_pkg`.** Holds:
  - the state enum (IDLE, ESPERA_PIN, ABIERTO, ALARMA, BLOQUEO);
  - a helper function for the timer width, $clog2(`T_ABIERTO`).
- **Sub-module `detector_intento`.** Contains the previous-`Pin` register and the edge compare, parametrised on `PIN_W` and `PIN_ESPERA`. It outputs `intento` and `pin_ok`.
- **Top level.** The FSM, the `Intentos` saturating counter and the open timer live in the top module.

## Test plan
All scenarios use the default parameters unless noted.
- **Nominal pass.** Reset at 5 ns, release at 15 ns; `Vehiculo`=1; `Pin`=8'h08 for 2 cycles, then 8'h00; `Termino`=1 for 1 cycle with `Vehiculo`=0 → `Abierto`=1 one cycle after the PIN, then `Cerrado`=1; `Intentos`=0 throughout.
- **Alarm and recovery.** Three wrong pulses (8'h01, 8'h02, 8'h03), each separated by 8'h00 → `Intentos`=1, 2, 3 and `Alarma`=1 after the third. A fourth wrong pulse leaves `Intentos`=3. Then 8'h08 → `Abierto`=1, `Alarma`=0, `Intentos`=0.
- **Held and repeated PIN.** Hold `Pin`=8'h01 for 10 cycles → `Intentos`=1. Change 8'h01 → 8'h02 directly → `Intentos` stays 1.
- **Tailgating.** In ABIERTO, `Termino`=1 with `Vehiculo`=1 → `Bloqueo`=1, `Alarma`=1, `Cerrado`=1. Wrong PIN → no change. 8'h08 → IDLE, all flags 0.
- **Timeout.** In ABIERTO with no `Termino` → `Cerrado`=1 exactly 20 cycles after `Abierto` rose. `Termino` and the timeout in the same cycle → IDLE via the `Termino` path.
- **Reset mid-operation and non-default parameters.**
  - Reset during ALARMA → all reset values at the next edge.
  - Rerun the alarm scenario with `PIN_W`=12, `MAX_INTENTOS`=5, `PIN_CORRECTO`=12'hA5C → alarm after the 5th wrong attempt.
